// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte-stream requesters, the UART TX arbiter and the TX serializer.
// Valid/ready rule: a byte moves on a cycle with valid && ready; valid, data and last stay stable until it moves.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_valid;
    logic [7:0]           tx_data;
    logic                 tx_ready;
    logic [2:0]           grant_id;
    logic                 busy;
    logic                 timeout;
    logic                 arb_state;  // debug view of the arbiter FSM: 0 = IDLE, 1 = LOCKED

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data, grant_id, busy, timeout, arb_state
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data, grant_id, busy, timeout, arb_state
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX serializer among NUM_REQ requesters.
// Optional stalled-grant revocation is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 4096
) (
    input logic              clk,
    input logic              n_rst,
    uart_tx_arbiter_if.slave bus
);
    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_e;

    state_e     state_q, state_d;
    logic [2:0] grant_q, grant_d;
    logic [2:0] rr_q, rr_d;
    logic       own_valid, own_last;
    logic [7:0] own_data;
    logic       xfer, expire;
    logic       hi_found, lo_found, pick_found;
    logic [2:0] hi_idx, lo_idx, pick_idx;

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == 3'(i)) begin
                own_valid = bus.req_valid[i];
                own_last  = bus.req_last[i];
                own_data  = bus.req_data[8*i +: 8];
            end
        end
    end

    // Round-robin pick: lowest requester at or above rr_q, else wrap to the lowest overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = 3'd0;
        lo_idx   = 3'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i] && !hi_found && (3'(i) >= rr_q)) begin
                hi_found = 1'b1;
                hi_idx   = 3'(i);
            end
            if (bus.req_valid[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = 3'(i);
            end
        end
        pick_found = lo_found;
        pick_idx   = hi_found ? hi_idx : lo_idx;
    end

    assign xfer = (state_q == ST_LOCKED) && own_valid && bus.tx_ready;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 12) ? $clog2(TIMEOUT + 1) : 12;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts only owner-silent cycles; a serializer stall keeps tx_valid high and freezes it.
    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (state_q != ST_LOCKED || xfer) begin
            cnt_d = '0;
        end else if (!own_valid) begin
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                expire = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign expire = 1'b0;

    // Revocation is absent in this build; TIMEOUT only sizes the optional counter.
    if (TIMEOUT < 2) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            grant_q <= 3'd0;
            rr_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_LOCKED;
                    grant_d = pick_idx;
                end
            end
            ST_LOCKED: begin
                if ((xfer && own_last) || expire) begin
                    state_d = ST_IDLE;
                    rr_d    = (grant_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.tx_valid  = (state_q == ST_LOCKED) && own_valid;
        bus.tx_data   = (state_q == ST_LOCKED) ? own_data : 8'h00;
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((state_q == ST_LOCKED) && (grant_q == 3'(i))) bus.req_ready[i] = bus.tx_ready;
        end
        bus.busy      = (state_q == ST_LOCKED);
        bus.grant_id  = grant_q;
        bus.timeout   = expire;
        bus.arb_state = state_q;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized packet traffic scored
// against a packet-level round-robin model.
module tb_uart_tx_arbiter;
    localparam int N   = 2;
    localparam int TMO = 16;

    logic clk   = 1'b0;
    logic n_rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] dq [N][$];   // driver side: bytes still to present, {last, data}
    logic [8:0] exp_q [N][$]; // model side: bytes still expected per requester
    logic [N-1:0] held, dstart, acc;
    int mo, mrr, rdy_mode, cyc;
    bit gap_en;
    int xf_g[$], xf_c[$];

    logic       tr_v [256];
    logic [7:0] tr_d [256];
    logic       tr_b [256];
    logic [2:0] tr_g [256];
    logic       tr_t [256];
    logic [N-1:0] tr_r [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] b, input logic last);
        dq[r].push_back({last, b});
        exp_q[r].push_back({last, b});
    endtask

    task automatic drive();
        logic [N-1:0] v, l;
        logic [N*8-1:0] d;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < N; i++) begin
            if (dq[i].size() > 0) begin
                if (!(gap_en && !dstart[i] && !held[i] && $urandom_range(0, 4) == 0)) v[i] = 1'b1;
                d[8*i +: 8] = dq[i][0][7:0];
                l[i]        = dq[i][0][8];
            end
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
        case (rdy_mode)
            0:       bus.tx_ready = 1'b0;
            1:       bus.tx_ready = 1'b1;
            default: bus.tx_ready = ($urandom_range(0, 9) < 7);
        endcase
    endtask

    // Model: a packet goes to the first requester with a pending packet from mrr upward.
    task automatic sb_transfer();
        logic last;
        if (mo < 0) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (mrr + k) % N;
                if (mo < 0 && exp_q[idx].size() > 0) mo = idx;
            end
        end
        if (mo < 0) begin
            chk("sb_spurious", 32'd1, 32'd0);
            return;
        end
        chk("sb_grant", 32'(bus.grant_id), mo);
        chk("sb_data", 32'(bus.tx_data), 32'(exp_q[mo][0][7:0]));
        chk("sb_ready", 32'(bus.req_ready), 32'(1 << mo));
        xf_g.push_back(mo);
        xf_c.push_back(cyc);
        last = exp_q[mo][0][8];
        void'(exp_q[mo].pop_front());
        if (last) begin
            mrr = (mo + 1) % N;
            mo  = -1;
        end
    endtask

    task automatic run_cycle();
        @(negedge clk);
        if (cyc < 256) begin
            tr_v[cyc] = bus.tx_valid;
            tr_d[cyc] = bus.tx_data;
            tr_b[cyc] = bus.busy;
            tr_g[cyc] = bus.grant_id;
            tr_t[cyc] = bus.timeout;
            tr_r[cyc] = bus.req_ready;
        end
        for (int i = 0; i < N; i++) acc[i] = bus.req_valid[i] && bus.req_ready[i];
        if (bus.tx_valid && bus.tx_ready) sb_transfer();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            held[i] = bus.req_valid[i] && !acc[i];
            if (acc[i]) begin
                dstart[i] = dq[i][0][8];
                void'(dq[i].pop_front());
            end
        end
        drive();
        cyc++;
    endtask

    task automatic model_reset();
        mo = -1; mrr = 0; cyc = 0;
        for (int i = 0; i < N; i++) begin
            dq[i].delete();
            exp_q[i].delete();
        end
        held = '0; dstart = '1; acc = '0;
        xf_g.delete();
        xf_c.delete();
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        model_reset();
        rdy_mode = 1;
        gap_en   = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        n_rst = 1'b1;
        cyc   = 0;
    endtask

    function automatic int pending();
        int p;
        p = (mo >= 0) ? 1 : 0;
        for (int i = 0; i < N; i++) p += exp_q[i].size() + dq[i].size();
        return p;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ev [8] = '{0, 1, 1, 1, 0, 1, 1, 0};
        int ed [8] = '{0, 'h41, 'h42, 'h43, 0, 'h61, 'h62, 0};
        int eg [8] = '{0, 0, 0, 0, 0, 1, 1, 0};

        // Reset holds everything quiet even with both requesters asking.
        #1;
        do_reset();
        bus.req_valid = 2'b11;
        @(negedge clk);
        chk("rst_tx_valid", 32'(bus.tx_valid), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_grant", 32'(bus.grant_id), 0);
        chk("rst_timeout", 32'(bus.timeout), 0);

        // Contention: packets never interleave, one idle cycle between them.
        do_reset();
        push(0, 8'h41, 0); push(0, 8'h42, 0); push(0, 8'h43, 1);
        push(1, 8'h61, 0); push(1, 8'h62, 1);
        drive();
        start_run();
        repeat (8) run_cycle();
        for (int c = 0; c < 8; c++) begin
            chk("t2_valid", 32'(tr_v[c]), ev[c]);
            chk("t2_busy", 32'(tr_b[c]), ev[c]);
            if (ev[c] != 0) begin
                chk("t2_data", 32'(tr_d[c]), ed[c]);
                chk("t2_grant", 32'(tr_g[c]), eg[c]);
            end
        end

        // Fairness: single-byte packets from both, owners alternate every other cycle.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push(0, 8'($urandom_range(0, 255)), 1);
            push(1, 8'($urandom_range(0, 255)), 1);
        end
        drive();
        start_run();
        repeat (18) run_cycle();
        chk("t3_count", xf_g.size(), 8);
        for (int k = 0; k < xf_g.size() && k < 8; k++) begin
            chk("t3_owner", xf_g[k], k % 2);
            chk("t3_slot", xf_c[k], 2 * k + 1);
        end

        // Backpressure: a stalled owner keeps the grant and the stall is never a timeout.
        do_reset();
        push(0, 8'h55, 1); push(1, 8'h77, 1);
        rdy_mode = 0;
        drive();
        start_run();
        run_cycle();
        repeat (20) begin
            run_cycle();
            chk("t4_valid", 32'(tr_v[cyc-1]), 1);
            chk("t4_data", 32'(tr_d[cyc-1]), 'h55);
            chk("t4_grant", 32'(tr_g[cyc-1]), 0);
            chk("t4_ready", 32'(tr_r[cyc-1]), 0);
            chk("t4_timeout", 32'(tr_t[cyc-1]), 0);
        end
        rdy_mode = 1;
        drive();
        repeat (6) run_cycle();
        chk("t4_drain", xf_g.size(), 2);
        if (xf_g.size() == 2) chk("t4_second_owner", xf_g[1], 1);

        // Owner goes silent after one non-last byte.
        do_reset();
        push(0, 8'h10, 0); push(1, 8'h20, 1);
        drive();
        start_run();
`ifdef UART_ARB_TIMEOUT_EN
        for (int c = 0; c < 22; c++) begin
            run_cycle();
            if (c == 17) begin
                mrr = (mo + 1) % N;
                mo  = -1;
            end
        end
        for (int c = 0; c < 22; c++) begin
            chk("t5_timeout", 32'(tr_t[c]), (c == 17) ? 1 : 0);
            chk("t5_busy", 32'(tr_b[c]), ((c >= 1 && c <= 17) || c == 19) ? 1 : 0);
        end
        chk("t5_next_data", 32'(tr_d[19]), 'h20);
        chk("t5_next_grant", 32'(tr_g[19]), 1);
        chk("t5_count", xf_g.size(), 2);
`else
        repeat (2) run_cycle();
        repeat (120) begin
            run_cycle();
            chk("t5_busy", 32'(tr_b[cyc-1]), 1);
            chk("t5_grant", 32'(tr_g[cyc-1]), 0);
            chk("t5_timeout", 32'(tr_t[cyc-1]), 0);
        end
        push(0, 8'h11, 1);
        drive();
        repeat (8) run_cycle();
        chk("t5_count", xf_g.size(), 3);
        if (xf_g.size() == 3) chk("t5_last_owner", xf_g[2], 1);
`endif

        // Reset mid-packet from requester 1, then arbitration restarts at requester 0.
        do_reset();
        push(0, 8'hA0, 1);
        for (int k = 0; k < 5; k++) push(1, 8'(8'hC0 + k), k == 4);
        drive();
        start_run();
        repeat (5) run_cycle();
        #2;
        chk("t6_pre_valid", 32'(bus.tx_valid), 1);
        n_rst = 1'b0;
        #1;
        chk("t6_tx_valid", 32'(bus.tx_valid), 0);
        chk("t6_req_ready", 32'(bus.req_ready), 0);
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_grant", 32'(bus.grant_id), 0);
        chk("t6_timeout", 32'(bus.timeout), 0);
        model_reset();
        push(0, 8'hD0, 1); push(1, 8'hD1, 1);
        drive();
        @(posedge clk);
        #1;
        start_run();
        repeat (5) run_cycle();
        chk("t6_count", xf_g.size(), 2);
        if (xf_g.size() == 2) begin
            chk("t6_first_owner", xf_g[0], 0);
            chk("t6_second_owner", xf_g[1], 1);
        end

        // Random packets, random serializer stalls, mid-packet valid gaps.
        for (int r = 0; r < 4; r++) begin
            int k;
            do_reset();
            for (int i = 0; i < N; i++) begin
                int np;
                np = $urandom_range(2, 5);
                for (int p = 0; p < np; p++) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) push(i, 8'($urandom_range(0, 255)), b == len - 1);
                end
            end
            rdy_mode = 2;
            gap_en   = 1'b1;
            drive();
            start_run();
            k = 0;
            while (pending() > 0 && k < 3000) begin
                run_cycle();
                k++;
            end
            chk("rnd_left_pending", pending(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
